// File: rtl/lut_pkg.sv
// Shared definitions for the programmable lookup table: power-up table
// contents, FSM state encoding and the reset-entry helper.
package lut_pkg;

  // Power-up contents of the first 16 entries (8 bits each).
  localparam logic [7:0] DEFAULT_TABLE [16] = '{
    8'h09, 8'h03, 8'h1F, 8'h19, 8'h08, 8'h06, 8'h0C, 8'h0C,
    8'h03, 8'h01, 8'h0A, 8'h04, 8'h05, 8'h1D, 8'h09, 8'h08
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } lut_state_t;

  // Reset value of entry addr, truncated to out_w bits; entries past the
  // default table reset to zero.
  function automatic logic [31:0] default_entry(input int unsigned addr,
                                                input int unsigned out_w);
    logic [31:0] v;
    v = (addr < 16) ? {24'h0, DEFAULT_TABLE[addr[3:0]]} : 32'h0;
    if (out_w < 32) v = v & ((32'h1 << out_w) - 32'h1);
    return v;
  endfunction

endpackage

// File: rtl/lut_mem.sv
// Table storage: reloads the default contents on reset, one write port,
// and a combinational read that returns the data being written this cycle
// when read and write hit the same address.
module lut_mem
  import lut_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic [IN_W-1:0]  rd_addr,
  output logic [OUT_W-1:0] rd_data
);

  localparam int DEPTH = 1 << IN_W;

  logic [OUT_W-1:0] mem [DEPTH];

  // Reset reload of the default table, otherwise apply the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= OUT_W'(default_entry(a, OUT_W));
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first bypass so a same-cycle lookup sees the new value.
  always_comb begin
    rd_data = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
  end

endmodule

// File: rtl/prog_lut.sv
// Writable lookup table with a single-entry registered output buffer and a
// self-test scan that emits every entry in address order.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready; once out_valid is high, out_data
// and out_addr stay put until the edge where out_ready is also high.
module prog_lut
  import lut_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IN_W-1:0]  out_addr,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             dbg_state
);

  lut_state_t       state;
  logic [IN_W:0]    cnt;       // extra MSB marks "all entries issued"
  logic             free;
  logic             accept;
  logic             issue;
  logic             last_hs;
  logic [IN_W-1:0]  rd_addr;
  logic [OUT_W-1:0] rd_data;

  // The scan holds SCAN through its scan_done cycle, so in_ready stays low
  // until the cycle after the pulse.
  assign free      = !out_valid || out_ready;
  assign in_ready  = free && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign issue     = (state == SCAN) && free && !cnt[IN_W];
  assign last_hs   = (state == SCAN) && cnt[IN_W] && out_valid && out_ready;
  assign rd_addr   = (state == SCAN) ? cnt[IN_W-1:0] : in_data;
  assign scan_busy = (state == SCAN);
  assign dbg_state = state;

  lut_mem #(.IN_W(IN_W), .OUT_W(OUT_W)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // FSM, scan counter and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept || issue) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
        out_addr  <= rd_addr;
      end
      case (state)
        IDLE: begin
          if (scan_start) begin
            state <= SCAN;
            cnt   <= '0;
          end
        end
        SCAN: begin
          if (issue)     cnt       <= cnt + (IN_W+1)'(1);
          if (last_hs)   scan_done <= 1'b1;
          if (scan_done) state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_lut.sv
// Directed bench for prog_lut: table model plus a result queue, checked by
// one compare process on every falling edge.
module tb_prog_lut;

  localparam int IN_W  = 4;
  localparam int OUT_W = 5;
  localparam int W     = IN_W + OUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             wr_en, in_valid, in_ready, out_valid, out_ready;
  logic             scan_start, scan_busy, scan_done, dbg_state;
  logic [IN_W-1:0]  wr_addr, in_data, out_addr;
  logic [OUT_W-1:0] wr_data, out_data;

  prog_lut #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- model ----------------
  logic [OUT_W-1:0] dflt [16] = '{5'h09, 5'h03, 5'h1F, 5'h19, 5'h08, 5'h06, 5'h0C, 5'h0C,
                                  5'h03, 5'h01, 5'h0A, 5'h04, 5'h05, 5'h1D, 5'h09, 5'h08};
  logic [OUT_W-1:0] mtab [16];
  logic [OUT_W-1:0] scan_seen [16];
  logic [W-1:0]     exp_q[$];

  int   vecs = 0;
  int   errs = 0;
  int   hs_cnt = 0;
  logic scan_exp = 1'b0;
  logic done_due = 1'b0;
  logic prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic [IN_W-1:0]  prev_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model write: update the table and any queued scan entry not yet issued.
  task automatic model_write(input logic [IN_W-1:0] wa, input logic [OUT_W-1:0] wd,
                             input int issued_upto);
    mtab[wa] = wd;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i][W-1:OUT_W] == wa && int'(wa) > issued_upto)
        exp_q[i][OUT_W-1:0] = wd;
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin : compare
    logic [W-1:0] e;
    logic         hs_last;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        done_due   = 1'b0;
      end else begin
        hs_last = 1'b0;
        check("scan_done", scan_done, done_due);
        if (scan_exp) check("in_ready_scan", in_ready, 0);
        if (!done_due) check("scan_busy", scan_busy, scan_exp);
        if (done_due) scan_exp = 1'b0;
        if (out_valid) begin
          if (prev_stall) begin
            check("hold_data", out_data, prev_data);
            check("hold_addr", out_addr, prev_addr);
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("spurious_valid", out_valid, 0);
            end else begin
              e = exp_q.pop_front();
              check("out_addr", out_addr, e[W-1:OUT_W]);
              check("out_data", out_data, e[OUT_W-1:0]);
              hs_cnt++;
              if (scan_exp) begin
                scan_seen[out_addr] = out_data;
                if (out_addr == IN_W'(15)) hs_last = 1'b1;
              end
            end
          end
          prev_stall = !out_ready;
          prev_data  = out_data;
          prev_addr  = out_addr;
        end else begin
          prev_stall = 1'b0;
        end
        done_due = hs_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [IN_W-1:0] a, input logic w,
                      input logic [IN_W-1:0] wa, input logic [OUT_W-1:0] wd, input logic rdy);
    in_valid = v; in_data = a; wr_en = w; wr_addr = wa; wr_data = wd; out_ready = rdy;
    @(negedge clk);
    if (v && in_ready) exp_q.push_back({a, (w && wa == a) ? wd : mtab[a]});
    if (w) mtab[wa] = wd;
    @(posedge clk); #1;
  endtask

  task automatic run_scan(input int wr_at, input int rst_at);
    int wr_phase;
    bit stop;
    wr_phase = 0;
    stop = 1'b0;
    in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1; scan_start = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) exp_q.push_back({IN_W'(a), mtab[a]});
    @(posedge clk); #1;
    scan_start = 1'b0; scan_exp = 1'b1; in_valid = 1'b1; in_data = IN_W'(7);
    for (int c = 0; c < 200 && !stop; c++) begin
      out_ready = c[0];
      wr_en = 1'b0;
      if (wr_phase == 1) begin
        wr_en = 1'b1; wr_addr = IN_W'(10); wr_data = 5'h00;
        model_write(IN_W'(10), 5'h00, wr_at + 2);
        wr_phase = 2;
      end else if (wr_phase == 2) begin
        wr_en = 1'b1; wr_addr = IN_W'(3); wr_data = 5'h1E;
        model_write(IN_W'(3), 5'h1E, wr_at + 2);
        wr_phase = 3;
      end
      @(negedge clk);
      if (out_valid && wr_at >= 0 && wr_phase == 0 && int'(out_addr) == wr_at) wr_phase = 1;
      if (out_valid && rst_at >= 0 && int'(out_addr) == rst_at) begin
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; wr_en = 1'b0;
        exp_q.delete(); scan_exp = 1'b0; mtab = dflt;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check("rst_mid_valid", out_valid, 0);
          check("rst_mid_busy", scan_busy, 0);
          check("rst_mid_done", scan_done, 0);
          @(posedge clk); #1;
        end
        stop = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (!scan_exp) stop = 1'b1;
      end
    end
    if (scan_exp) begin
      check("scan_timeout", scan_exp, 0);
      scan_exp = 1'b0;
    end
    in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    in_valid = 1'b0; in_data = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    out_ready = 1'b1; scan_start = 1'b0;
    mtab = dflt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_scan_busy", scan_busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_in_ready", in_ready, 1);

    // Back-to-back lookups of the default table
    for (int a = 0; a < 16; a++) step(1'b1, IN_W'(a), 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("t1_results", hs_cnt, 16);
    check("t1_drained", exp_q.size(), 0);

    // Write then look up; same-cycle write/lookup bypass
    step(1'b0, '0, 1'b1, IN_W'(2), 5'h07, 1'b1);
    step(1'b1, IN_W'(2), 1'b0, '0, '0, 1'b1);
    check("wr_lookup2", out_data, 5'h07);
    step(1'b1, IN_W'(5), 1'b1, IN_W'(5), 5'h11, 1'b1);
    check("bypass5", out_data, 5'h11);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);

    // Backpressure hold
    step(1'b1, IN_W'(3), 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, IN_W'(4), 1'b0, '0, '0, 1'b0);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 5'h19);
      check("bp_addr", out_addr, 3);
      check("bp_in_ready", in_ready, 0);
    end
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("bp_drained", exp_q.size(), 0);

    // Plain scan with toggling out_ready
    run_scan(-1, -1);
    check("scan1_drained", exp_q.size(), 0);
    check("post_scan_ready", in_ready, 1);
    step(1'b1, IN_W'(9), 1'b0, '0, '0, 1'b1);
    check("post_scan_lookup", out_data, 5'h01);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);

    // Scan with writes issued around address 6
    run_scan(6, -1);
    check("scan2_drained", exp_q.size(), 0);
    check("scan2_a10", scan_seen[10], 5'h00);
    check("scan2_a3", scan_seen[3], 5'h19);
    check("scan2_a2", scan_seen[2], 5'h07);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);

    // Reset in the middle of a scan restores defaults
    run_scan(-1, 8);
    step(1'b1, IN_W'(2), 1'b0, '0, '0, 1'b1);
    check("rst_lookup2", out_data, 5'h1F);
    step(1'b1, IN_W'(3), 1'b0, '0, '0, 1'b1);
    check("rst_lookup3", out_data, 5'h19);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("final_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
